// File: rtl/sprite_program_scheduler.sv
// Buffers sprite update requests in a small FIFO and replays them onto the shared
// sprite programming bus during vertical blank; also sequences the chain-wide clear.
module sprite_program_scheduler #(
  parameter int FIFO_DEPTH    = 4,
  parameter int NUM_SPRITES   = 8,
  parameter int VISIBLE_LINES = 240,
  parameter int SETUP_CYCLES  = 2,
  parameter int PULSE_CYCLES  = 2
) (
  input  logic                          clk,
  input  logic                          clear_n,
  input  logic [7:0]                    screenY,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [5:0]                    req_id,
  input  logic [7:0]                    req_x,
  input  logic [7:0]                    req_y,
  input  logic [15:0]                   req_addr,
  input  logic                          clear_req,
  output logic [5:0]                    requested_sprite_id,
  output logic [7:0]                    setx,
  output logic [7:0]                    sety,
  output logic [15:0]                   set_address,
  output logic                          program_active,
  output logic                          clear,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    dropped_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [5:0]  id;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] addr;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_CLEAR
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic [LW-1:0]   level_q, level_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  entry_t          mem_q [FIFO_DEPTH];
  entry_t          mem_d [FIFO_DEPTH];
  entry_t          bus_q, bus_d;
  logic [7:0]      dropped_q, dropped_d;

  logic            vblank;
  logic            id_valid;
  logic            accept;
  logic            push;
  logic            drop;
  logic            pop;
  logic            flush;
  entry_t          req_entry;

  assign vblank    = ({1'b0, screenY} >= 9'(VISIBLE_LINES));
  assign id_valid  = ({1'b0, req_id} < 7'(NUM_SPRITES));
  // Ready looks only at the registered level, so a same-cycle pop never lets a full FIFO accept.
  assign req_ready = clear_n && (level_q < LW'(FIFO_DEPTH)) && (state_q != ST_CLEAR);
  assign accept    = req_valid && req_ready;
  assign push      = accept && id_valid;
  assign drop      = accept && !id_valid;
  assign req_entry = '{id: req_id, x: req_x, y: req_y, addr: req_addr};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bus_d   = bus_q;
    pop     = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (vblank && (level_q != '0)) begin
          pop     = 1'b1;
          bus_d   = mem_q[rd_ptr_q];
          state_d = ST_SETUP;
          cnt_d   = '0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 8'(SETUP_CYCLES - 1)) begin
          state_d = ST_PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == 8'(PULSE_CYCLES - 1)) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        if (cnt_q == 8'd0) begin
          flush = 1'b1;
          cnt_d = 8'd1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A clear request arriving mid-update is parked here until the sequence returns to idle.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = 1'b0;
    end
    if (clear_req && (state_q != ST_CLEAR)) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    dropped_d = dropped_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = req_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        level_d = level_q + 1'b1;
      end else if (pop && !push) begin
        level_d = level_q - 1'b1;
      end
    end
    if (drop && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      level_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_q     <= '{default: '0};
      bus_q     <= '0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      level_q   <= level_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_q     <= mem_d;
      bus_q     <= bus_d;
      dropped_q <= dropped_d;
    end
  end

  assign requested_sprite_id = bus_q.id;
  assign setx                = bus_q.x;
  assign sety                = bus_q.y;
  assign set_address         = bus_q.addr;
  assign program_active      = (state_q == ST_PULSE);
  assign clear               = (state_q == ST_CLEAR);
  assign busy                = (state_q != ST_IDLE);
  assign fifo_level          = level_q;
  assign dropped_count       = dropped_q;

endmodule

// File: tb/tb_sprite_program_scheduler.sv
// Directed bench for sprite_program_scheduler: a vector table for the basic update
// and drop paths, plus hand-written sequences for full FIFO, clear, vblank and reset corners.
module tb_sprite_program_scheduler;

  logic        clk = 1'b0;
  logic        clear_n;
  logic [7:0]  screenY;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_id;
  logic [7:0]  req_x;
  logic [7:0]  req_y;
  logic [15:0] req_addr;
  logic        clear_req;
  logic [5:0]  requested_sprite_id;
  logic [7:0]  setx;
  logic [7:0]  sety;
  logic [15:0] set_address;
  logic        program_active;
  logic        clear;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [7:0]  dropped_count;

  always #5 clk = ~clk;

  sprite_program_scheduler dut (
    .clk                 (clk),
    .clear_n             (clear_n),
    .screenY             (screenY),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_id              (req_id),
    .req_x               (req_x),
    .req_y               (req_y),
    .req_addr            (req_addr),
    .clear_req           (clear_req),
    .requested_sprite_id (requested_sprite_id),
    .setx                (setx),
    .sety                (sety),
    .set_address         (set_address),
    .program_active      (program_active),
    .clear               (clear),
    .busy                (busy),
    .fifo_level          (fifo_level),
    .dropped_count       (dropped_count)
  );

  typedef struct packed {
    logic        pa;
    logic        clr;
    logic        busy;
    logic        ready;
    logic [2:0]  level;
    logic [7:0]  dropped;
    logic [5:0]  id;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] addr;
  } out_t;

  typedef struct {
    logic        rst_n;
    logic [7:0]  sy;
    logic        valid;
    logic [5:0]  id;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] addr;
    logic        clr_req;
    out_t        exp;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  function automatic out_t mk(input logic pa, input logic clr, input logic bsy, input logic rdy,
                              input logic [2:0] level, input logic [7:0] dropped,
                              input logic [5:0] id, input logic [7:0] x, input logic [7:0] y,
                              input logic [15:0] addr);
    out_t o;
    o = '{pa: pa, clr: clr, busy: bsy, ready: rdy, level: level, dropped: dropped,
          id: id, x: x, y: y, addr: addr};
    return o;
  endfunction

  function automatic vec_t mkv(input logic rst_n, input logic [7:0] sy, input logic valid,
                               input logic [5:0] id, input logic [7:0] x, input logic [7:0] y,
                               input logic [15:0] addr, input logic clr_req, input out_t exp);
    vec_t v;
    v = '{rst_n: rst_n, sy: sy, valid: valid, id: id, x: x, y: y, addr: addr,
          clr_req: clr_req, exp: exp};
    return v;
  endfunction

  function automatic out_t sampleOutputs();
    return mk(program_active, clear, busy, req_ready, fifo_level, dropped_count,
              requested_sprite_id, setx, sety, set_address);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    clear_n   = v.rst_n;
    screenY   = v.sy;
    req_valid = v.valid;
    req_id    = v.id;
    req_x     = v.x;
    req_y     = v.y;
    req_addr  = v.addr;
    clear_req = v.clr_req;
    tick();
  endtask

  task automatic doReset();
    clear_n   = 1'b0;
    req_valid = 1'b0;
    clear_req = 1'b0;
    screenY   = 8'd10;
    tick();
    clear_n = 1'b1;
  endtask

  task automatic push(input logic [5:0] id, input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] addr);
    req_valid = 1'b1;
    req_id    = id;
    req_x     = x;
    req_y     = y;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
  endtask

  vec_t       vecs [12];
  logic [5:0] exp_ids [5];
  logic [7:0] exp_xs [5];

  initial begin
    int   k;
    int   last_rise;
    int   highs;
    logic prev_pa;

    vecs[0]  = mkv(1'b0, 8'd0,   1'b0, 6'd0,  8'd0,  8'd0,  16'h0000, 1'b0,
                   mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 6'd0, 8'd0,  8'd0,  16'h0000));
    vecs[1]  = mkv(1'b1, 8'd10,  1'b1, 6'd3,  8'd20, 8'd30, 16'h0100, 1'b0,
                   mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'd0, 6'd0, 8'd0,  8'd0,  16'h0000));
    vecs[2]  = mkv(1'b1, 8'd10,  1'b0, 6'd0,  8'd0,  8'd0,  16'h0000, 1'b0,
                   mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'd0, 6'd0, 8'd0,  8'd0,  16'h0000));
    vecs[3]  = mkv(1'b1, 8'd240, 1'b0, 6'd0,  8'd0,  8'd0,  16'h0000, 1'b0,
                   mk(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'd0, 6'd3, 8'd20, 8'd30, 16'h0100));
    vecs[4]  = mkv(1'b1, 8'd240, 1'b0, 6'd0,  8'd0,  8'd0,  16'h0000, 1'b0,
                   mk(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'd0, 6'd3, 8'd20, 8'd30, 16'h0100));
    vecs[5]  = mkv(1'b1, 8'd240, 1'b0, 6'd0,  8'd0,  8'd0,  16'h0000, 1'b0,
                   mk(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'd0, 6'd3, 8'd20, 8'd30, 16'h0100));
    vecs[6]  = mkv(1'b1, 8'd240, 1'b0, 6'd0,  8'd0,  8'd0,  16'h0000, 1'b0,
                   mk(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'd0, 6'd3, 8'd20, 8'd30, 16'h0100));
    vecs[7]  = mkv(1'b1, 8'd240, 1'b0, 6'd0,  8'd0,  8'd0,  16'h0000, 1'b0,
                   mk(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'd0, 6'd3, 8'd20, 8'd30, 16'h0100));
    vecs[8]  = mkv(1'b1, 8'd240, 1'b0, 6'd0,  8'd0,  8'd0,  16'h0000, 1'b0,
                   mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'd0, 6'd3, 8'd20, 8'd30, 16'h0100));
    vecs[9]  = mkv(1'b1, 8'd10,  1'b1, 6'd8,  8'd1,  8'd2,  16'h0003, 1'b0,
                   mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'd1, 6'd3, 8'd20, 8'd30, 16'h0100));
    vecs[10] = mkv(1'b1, 8'd10,  1'b1, 6'd63, 8'd4,  8'd5,  16'h0006, 1'b0,
                   mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'd2, 6'd3, 8'd20, 8'd30, 16'h0100));
    vecs[11] = mkv(1'b1, 8'd240, 1'b0, 6'd0,  8'd0,  8'd0,  16'h0000, 1'b0,
                   mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'd2, 6'd3, 8'd20, 8'd30, 16'h0100));

    exp_ids = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd5};
    exp_xs  = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd99};

    clear_n   = 1'b0;
    screenY   = 8'd0;
    req_valid = 1'b0;
    req_id    = 6'd0;
    req_x     = 8'd0;
    req_y     = 8'd0;
    req_addr  = 16'h0000;
    clear_req = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), 64'(sampleOutputs()), 64'(vecs[i].exp));
    end

    // Full FIFO back-pressure, then FIFO-ordered drain at one update per six cycles
    doReset();
    for (int i = 0; i < 4; i++) begin
      push(6'(i), 8'(10 + i), 8'(20 + i), 16'(16'h1000 + i));
    end
    checkOutput("fullReady", 64'({req_ready, fifo_level}), 64'({1'b0, 3'd4}));
    req_valid = 1'b1;
    req_id    = 6'd5;
    req_x     = 8'd99;
    req_y     = 8'd98;
    req_addr  = 16'h2222;
    tick();
    tick();
    checkOutput("fullHold", 64'({req_ready, fifo_level, busy}), 64'({1'b0, 3'd4, 1'b0}));
    screenY = 8'd240;
    tick();
    checkOutput("popFromFull", 64'({req_ready, fifo_level, busy}), 64'({1'b1, 3'd3, 1'b1}));
    tick();
    req_valid = 1'b0;
    checkOutput("fifthAccepted", 64'(fifo_level), 64'(3'd4));
    k         = 0;
    last_rise = 0;
    highs     = 0;
    prev_pa   = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (program_active) highs++;
      if (program_active && !prev_pa) begin
        if (k < 5) begin
          checkOutput($sformatf("order%0d", k), 64'({requested_sprite_id, setx}),
                      64'({exp_ids[k], exp_xs[k]}));
        end
        if (k > 0) begin
          checkOutput($sformatf("spacing%0d", k), 64'(c - last_rise), 64'(6));
        end
        last_rise = c;
        k++;
      end
      prev_pa = program_active;
    end
    checkOutput("pulseCount", 64'(k), 64'(5));
    checkOutput("pulseHighCycles", 64'(highs), 64'(10));
    checkOutput("drainedLevel", 64'(fifo_level), 64'(3'd0));

    // Saturation of the invalid-id counter
    doReset();
    req_valid = 1'b1;
    req_id    = 6'd40;
    for (int i = 0; i < 300; i++) tick();
    req_valid = 1'b0;
    checkOutput("dropSaturate", 64'({dropped_count, fifo_level}), 64'({8'd255, 3'd0}));

    // Clear request arriving mid-pulse waits, then flushes the second entry
    doReset();
    push(6'd1, 8'd11, 8'd12, 16'h0011);
    push(6'd2, 8'd21, 8'd22, 16'h0022);
    screenY = 8'd240;
    tick();
    tick();
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    checkOutput("clrMidPulse", 64'({program_active, clear}), 64'({1'b1, 1'b0}));
    tick();
    checkOutput("clrHold", 64'({program_active, clear, busy}), 64'({1'b0, 1'b0, 1'b1}));
    tick();
    tick();
    checkOutput("clrFirst", 64'({clear, req_ready, busy}), 64'({1'b1, 1'b0, 1'b1}));
    tick();
    checkOutput("clrSecond", 64'({clear, req_ready, fifo_level}), 64'({1'b1, 1'b0, 3'd0}));
    tick();
    checkOutput("clrDone", 64'({clear, req_ready, busy, fifo_level}),
                64'({1'b0, 1'b1, 1'b0, 3'd0}));
    highs = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (program_active) highs++;
    end
    checkOutput("noIssueAfterClr", 64'({highs, 2'(0), requested_sprite_id}), 64'({32'd0, 2'(0), 6'd1}));

    // Vertical blank ending during setup does not abort the started update
    doReset();
    push(6'd4, 8'd41, 8'd42, 16'h0044);
    push(6'd5, 8'd51, 8'd52, 16'h0055);
    screenY = 8'd255;
    tick();
    screenY = 8'd0;
    tick();
    tick();
    checkOutput("vbEndPulse1", 64'({program_active, requested_sprite_id}), 64'({1'b1, 6'd4}));
    tick();
    checkOutput("vbEndPulse2", 64'(program_active), 64'(1'b1));
    highs = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (program_active) highs++;
    end
    checkOutput("waitForVblank", 64'({highs, fifo_level, busy}), 64'({32'd0, 3'd1, 1'b0}));
    screenY = 8'd240;
    tick();
    checkOutput("secondIssue", 64'({busy, requested_sprite_id, fifo_level}),
                64'({1'b1, 6'd5, 3'd0}));

    // Reset asserted mid-pulse returns everything to zero
    doReset();
    push(6'd6, 8'd61, 8'd62, 16'h0066);
    push(6'd7, 8'd71, 8'd72, 16'h0077);
    screenY = 8'd240;
    tick();
    tick();
    tick();
    checkOutput("preResetPulse", 64'(program_active), 64'(1'b1));
    clear_n = 1'b0;
    tick();
    checkOutput("resetMidPulse", 64'(sampleOutputs()), 64'(out_t'('0)));
    clear_n = 1'b1;
    screenY = 8'd10;
    tick();
    checkOutput("afterRelease", 64'({req_ready, busy, fifo_level}), 64'({1'b1, 1'b0, 3'd0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
